ram_boot_loader: RTL



---
 rtl/ram_boot_pkg.sv | 6 +
 rtl/ram_boot_loader_packer.sv | 38 +++
 rtl/ram_boot_loader.sv | 91 +++++++++
 3 files changed

// File: rtl/ram_boot_pkg.sv
// ram_boot_pkg: shared states and framing constants for the RAM boot loader
package ram_boot_pkg;
    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERROR} state_t;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/ram_boot_loader_packer.sv
// boot_word_packer: assembles little-endian bytes into 32-bit words
module boot_word_packer
    import ram_boot_pkg::*;
(
    input  logic        pclk,
    input  logic        RESET,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        lane_last,
    output logic        word_valid,
    output logic [31:0] word
);
    localparam int LW = $clog2(BYTES_PER_WORD);
    logic [LW-1:0] lane;
    logic [31:0]   sr;
    assign lane_last = lane == LW'(BYTES_PER_WORD - 1);
    // shift bytes in from the top so byte 0 ends up in bits 7:0; pulse on the last lane
    always_ff @(posedge pclk or negedge RESET) begin
        if (!RESET) begin
            lane       <= '0;
            sr         <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else if (clr) begin
            lane       <= '0;
            sr         <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && lane_last;
            if (byte_valid) begin
                sr   <= {byte_in, sr[31:8]};
                lane <= lane + LW'(1);
                if (lane_last) word <= {byte_in, sr[31:8]};
            end
        end
    end
endmodule

// File: rtl/ram_boot_loader.sv
// ram_boot_loader: loads a checksummed byte-stream image into RAM, then releases the core
module ram_boot_loader
    import ram_boot_pkg::*;
#(
    parameter int RAM_WORDS = 1536,
    parameter int ADDR_W    = 11,
    parameter int TIMEOUT   = 65535
) (
    input  logic              pclk,
    input  logic              RESET,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              core_resetn,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t                 state, next;
    logic [8*HDR_BYTES-1:0] n, n_full;
    logic [7:0]             acc;
    logic [TW-1:0]          tcnt;
    logic [ADDR_W:0]        ptr;
    logic                   accept, take_data, lane_last, last_word, restart_ok, timing, timed_out;
    assign accept     = in_valid && in_ready;
    assign take_data  = accept && state == DATA;
    assign n_full     = {in_data, n[8*HDR_BYTES-1:8]};
    assign restart_ok = restart && (state == DONE || state == ERROR);
    assign timing     = state == HDR1 || state == DATA || state == CSUM;
    assign timed_out  = timing && !accept && tcnt == TW'(TIMEOUT - 1);
    assign last_word  = lane_last && (32'(ptr) + 32'(ram_we) + 32'd1 == 32'(n));
    assign ram_addr     = ptr[ADDR_W-1:0];
    assign words_loaded = ptr;

    boot_word_packer u_packer (
        .pclk       (pclk),
        .RESET      (RESET),
        .clr        (restart_ok),
        .byte_valid (take_data),
        .byte_in    (in_data),
        .lane_last  (lane_last),
        .word_valid (ram_we),
        .word       (ram_wdata)
    );

    // next-state: header, payload, checksum, then park in DONE/ERROR until restart
    always_comb begin
        next = state;
        if (timed_out) next = ERROR;
        else begin
            unique case (state)
                HDR0:        next = accept ? HDR1 : HDR0;
                HDR1:        next = !accept ? HDR1 : 32'(n_full) > RAM_WORDS ? ERROR : n_full == '0 ? CSUM : DATA;
                DATA:        next = take_data && last_word ? CSUM : DATA;
                CSUM:        next = !accept ? CSUM : in_data == acc ? DONE : ERROR;
                DONE, ERROR: next = restart ? HDR0 : state;
                default:     next = HDR0;
            endcase
        end
    end

    // state, header capture, checksum, idle timer, write pointer and status flags
    always_ff @(posedge pclk or negedge RESET) begin
        if (!RESET) begin
            state       <= HDR0;
            in_ready    <= 1'b0;
            n           <= '0;
            acc         <= '0;
            tcnt        <= '0;
            ptr         <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            core_resetn <= 1'b0;
        end else begin
            state       <= next;
            in_ready    <= next == HDR0 || next == HDR1 || next == DATA || next == CSUM;
            n           <= accept && (state == HDR0 || state == HDR1) ? n_full : n;
            acc         <= restart_ok ? '0 : take_data ? acc ^ in_data : acc;
            tcnt        <= accept || !timing ? '0 : tcnt + TW'(1);
            ptr         <= restart_ok ? '0 : ram_we ? ptr + (ADDR_W + 1)'(1) : ptr;
            done        <= state == DONE && !restart;
            core_resetn <= state == DONE && !restart;
            error       <= next == ERROR;
        end
    end
endmodule
